// File: rtl/uart_rx_pkg.sv
// Shared UART receive/transmit definitions: FSM state encoding and parity-type constants.
// No logic; imported by the RX frame checker (and by the TX parity path for PAR_EVEN/PAR_ODD).
// Parity type 0 = even (bit equals XOR of data), 1 = odd (bit equals XNOR of data).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_deser.sv
// Data-bit deserializer: LSB-first shift register, bit counter and running XOR of received bits.
// Updates one cycle after i_en; clear has priority over enable.
// No backpressure: the FSM only enables it on qualified data-bit strobes.
module uart_rx_deser #(
  parameter int Width = 8,
  parameter int CW    = $clog2(Width + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [Width-1:0] o_shift,
  output logic [CW-1:0]    o_cnt,
  output logic             o_acc
);

  logic [Width-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_acc;

  // Shift new bits in from the top so the first received bit ends at position 0.
  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
    end else if (i_en) begin
      r_shift <= {i_bit, r_shift[Width-1:1]};
      r_cnt   <= r_cnt + CW'(1);
      r_acc   <= r_acc ^ i_bit;
    end
  end

  assign o_shift = r_shift;
  assign o_cnt   = r_cnt;
  assign o_acc   = r_acc;

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: validates start/parity/stop bits, assembles LSB-first data; optional error counter (UART_RX_ERR_CNT_EN).
// Latency: all pulses and the P_DATA update appear the cycle after the qualifying bit_strobe.
// No backpressure: data_valid is a one-cycle strobe; downstream must accept it.
module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int Width = 8
`ifdef UART_RX_ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             start_det,
  input  logic             bit_strobe,
  input  logic             sampled_bit,
  output logic [Width-1:0] P_DATA,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err,
  output logic             strt_glitch,
  output logic             busy
`ifdef UART_RX_ERR_CNT_EN
  , output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int CW = $clog2(Width + 1);

  rx_state_t        r_state;
  logic [Width-1:0] r_pdata;
  logic             r_dv;
  logic             r_pe;
  logic             r_se;
  logic             r_sg;
  logic             r_pen;
  logic             r_ptyp;
  logic             r_bad;

  logic [Width-1:0] w_shift;
  logic [CW-1:0]    w_cnt;
  logic             w_acc;
  logic             w_clr;
  logic             w_en;
  logic             w_last;
  logic             w_exp_par;

  // Clear on an accepted start bit so stale data never leaks into a new frame.
  assign w_clr     = (r_state == START) && bit_strobe && !sampled_bit;
  assign w_en      = (r_state == DATA) && bit_strobe;
  assign w_last    = (w_cnt == CW'(Width - 1));
  assign w_exp_par = w_acc ^ (r_ptyp == PAR_ODD);

  uart_rx_deser #(
    .Width (Width),
    .CW    (CW)
  ) u_deser (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_bit   (sampled_bit),
    .o_shift (w_shift),
    .o_cnt   (w_cnt),
    .o_acc   (w_acc)
  );

  // Frame FSM with registered strobes; parity settings are latched at START->DATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_pdata <= '0;
      r_dv    <= 1'b0;
      r_pe    <= 1'b0;
      r_se    <= 1'b0;
      r_sg    <= 1'b0;
      r_pen   <= 1'b0;
      r_ptyp  <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      r_sg <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_det) r_state <= START;
        end
        START: begin
          if (bit_strobe) begin
            if (sampled_bit) begin
              r_sg    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_pen   <= PAR_EN;
              r_ptyp  <= PAR_TYP;
              r_bad   <= 1'b0;
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_strobe && w_last) r_state <= r_pen ? PARITY : STOP;
        end
        PARITY: begin
          if (bit_strobe) begin
            if (sampled_bit != w_exp_par) begin
              r_pe  <= 1'b1;
              r_bad <= 1'b1;
            end
            r_state <= STOP;
          end
        end
        STOP: begin
          if (bit_strobe) begin
            if (!sampled_bit) begin
              r_se <= 1'b1;
            end else if (!r_bad) begin
              r_pdata <= w_shift;
              r_dv    <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign P_DATA      = r_pdata;
  assign data_valid  = r_dv;
  assign par_err     = r_pe;
  assign stp_err     = r_se;
  assign strt_glitch = r_sg;
  assign busy        = (r_state != IDLE);

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;
  logic [1:0]       w_inc;
  logic [CNT_W:0]   w_sum;

  assign w_inc = {1'b0, r_pe} + {1'b0, r_se} + {1'b0, r_sg};
  assign w_sum = {1'b0, r_err_cnt} + (CNT_W + 1)'(w_inc);

  // Saturating error count; all error strobes of one cycle are added in a single update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err_cnt <= '0;
    end else if (w_sum[CNT_W]) begin
      r_err_cnt <= '1;
    end else begin
      r_err_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Randomized scoreboard bench for uart_rx_frame_checker; expected strobes are queued at stimulus time.
// A negedge monitor pops one expected event per output pulse cycle and compares flags, P_DATA and err_cnt.
// Build with UART_RX_ERR_CNT_EN defined to exercise the saturating counter (CNT_W=2).
module tb_uart_rx_frame_checker;

  localparam int W = 8;
`ifdef UART_RX_ERR_CNT_EN
  localparam int CNT_W   = 2;
  localparam int ECNT_MAX = (1 << CNT_W) - 1;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         PAR_EN, PAR_TYP, start_det, bit_strobe, sampled_bit;
  logic [W-1:0] P_DATA;
  logic         data_valid, par_err, stp_err, strt_glitch, busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  uart_rx_frame_checker #(
    .Width (W)
`ifdef UART_RX_ERR_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .start_det   (start_det),
    .bit_strobe  (bit_strobe),
    .sampled_bit (sampled_bit),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_glitch (strt_glitch),
    .busy        (busy)
`ifdef UART_RX_ERR_CNT_EN
    , .err_cnt   (err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Expected output event: flags = {data_valid, par_err, stp_err, strt_glitch}
  typedef struct {
    logic [3:0] flags;
    logic [7:0] pdata;
    int         ecnt;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] m_pdata = 8'h00;   // model: last good frame's data
  int   m_ecnt = 0;              // model: error count

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_ev(input logic [3:0] flags);
    ev_t e;
    if (flags[2:0] != 3'b000) begin
`ifdef UART_RX_ERR_CNT_EN
      if (m_ecnt < ECNT_MAX) m_ecnt++;
`endif
    end
    e.flags = flags;
    e.pdata = m_pdata;
    e.ecnt  = m_ecnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One bit period: a single-cycle strobe followed by an idle gap
  task automatic strobe(input logic b);
    bit_strobe  = 1'b1;
    sampled_bit = b;
    tick();
    bit_strobe  = 1'b0;
    sampled_bit = 1'($urandom_range(0, 1));
    gap();
  endtask

  // Send one frame and queue the expected outcome computed from the frame rules
  task automatic frame(input logic [7:0] d, input logic pen, input logic ptyp,
                       input logic sb, input logic bad_par, input logic stopb,
                       input logic toggle, input logic same_cycle);
    logic perr;
    logic pbit;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    // Occasionally a stray strobe while idle; it must be ignored
    if ($urandom_range(0, 3) == 0) strobe(1'($urandom_range(0, 1)));
    start_det = 1'b1;
    if (same_cycle) begin
      bit_strobe  = 1'b1;
      sampled_bit = 1'b1;
    end
    tick();
    start_det  = 1'b0;
    bit_strobe = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    gap();

    if (sb) begin
      push_ev(4'b0001);
      strobe(1'b1);
      chk("busy_after_glitch", 32'(busy), 32'd0);
      return;
    end
    perr = pen && bad_par;
    if (perr) push_ev(4'b0100);
    if (!stopb) push_ev(4'b0010);
    else if (!perr) begin
      m_pdata = d;
      push_ev(4'b1000);
    end

    strobe(1'b0);
    for (int i = 0; i < 8; i++) begin
      strobe(d[i]);
      if (i == 3 && toggle) begin
        PAR_TYP = ~PAR_TYP;
        PAR_EN  = ~PAR_EN;
      end
      if (i == 5 && $urandom_range(0, 2) == 0) begin
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
      end
    end
    if (pen) begin
      pbit = (^d) ^ ptyp ^ bad_par;
      strobe(pbit);
    end
    strobe(stopb);
  endtask

  // Reset in the middle of the data bits: nothing is reported, P_DATA returns to 0
  task automatic reset_mid_frame();
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    gap();
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom_range(0, 1)));
    RST = 1'b1;
    tick();
    chk("busy_after_rst", 32'(busy), 32'd0);
    chk("pdata_after_rst", 32'(P_DATA), 32'd0);
    RST = 1'b0;
    m_pdata = 8'h00;
    m_ecnt  = 0;
    gap();
  endtask

  // Monitor: one expected event per cycle that shows any output strobe
  initial begin : monitor
    logic [3:0] obs;
    ev_t e;
    forever begin
      @(negedge CLK);
      obs = {data_valid, par_err, stp_err, strt_glitch};
      if (obs != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got=%b expected=none", obs);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_flags", 32'(obs), 32'(e.flags));
          chk("p_data", 32'(P_DATA), 32'(e.pdata));
`ifdef UART_RX_ERR_CNT_EN
          @(negedge CLK);
          chk("err_cnt", 32'(err_cnt), 32'(e.ecnt));
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d;
    logic sb, bad, stp;
    RST = 1'b1;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    start_det = 1'b0; bit_strobe = 1'b0; sampled_bit = 1'b0;
    repeat (3) tick();
    chk("rst_pdata", 32'(P_DATA), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({data_valid, par_err, stp_err, strt_glitch}), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    RST = 1'b0;
    tick();

    // Directed cases
    frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // good even-parity frame
    frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // odd parity, bit 0 sent
    frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // stop error
    frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // good, no parity
    frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // start glitch
    frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // good after glitch
    reset_mid_frame();
    frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // PAR_TYP/PAR_EN toggled mid-frame, good
    frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // toggled mid-frame, bad parity
    frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);  // start_det and strobe in same IDLE cycle

    // Error-count scenario: parity+stop error, then a glitch, then another error
    reset_mid_frame();
    frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'hE7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 9) == 0);
      bad = ($urandom_range(0, 4) == 0);
      stp = ($urandom_range(0, 4) != 0);
      frame(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sb, bad, stp,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    repeat (10) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
